// File: rtl/pipe_stage.sv
// Generic valid/ready pipeline stage register with flush, bubble payload and an
// optional 2-entry skid buffer that keeps in_ready fully registered.
module pipe_stage #(
  parameter int                DATA_W = 136,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter bit                SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_fresh,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              fresh_reg, fresh_next;
  logic              accept, drain;

  generate
    if (SKID) begin : g_skid
      // Registered ready: only depends on whether the skid slot is taken.
      assign in_ready = (state_reg != TWO);
    end else begin : g_single
      assign in_ready = (state_reg == EMPTY) | out_ready;
    end
  endgenerate

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign out_fresh = fresh_reg;
  assign occupancy = state_reg;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    fresh_next = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          main_next  = in_data;
          fresh_next = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_next  = in_data;
          fresh_next = 1'b1;
        end else if (accept) begin
          // Only reachable with the skid buffer; without it accept implies drain.
          if (SKID) begin
            state_next = TWO;
            skid_next  = in_data;
          end
        end else if (drain) begin
          state_next = EMPTY;
          main_next  = BUBBLE;
        end
      end
      TWO: begin
        if (drain) begin
          state_next = ONE;
          main_next  = skid_reg;
          skid_next  = BUBBLE;
          fresh_next = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
        main_next  = BUBBLE;
        skid_next  = BUBBLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_reg <= EMPTY;
      main_reg  <= BUBBLE;
      skid_reg  <= BUBBLE;
      fresh_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      fresh_reg <= fresh_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: drives a skid instance and a single-register instance with
// shared stimulus and compares both against a queue-based reference each cycle.
module tb_pipe_stage;

  localparam int W = 136;
  localparam logic [W-1:0] BUB1 = '0;
  localparam logic [W-1:0] BUB0 = W'(8'h13);

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         in_ready1, out_valid1, out_fresh1;
  logic [W-1:0] out_data1;
  logic [1:0]   occ1;
  logic         in_ready0, out_valid0, out_fresh0;
  logic [W-1:0] out_data0;
  logic [1:0]   occ0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: held entries in order, plus the expected out_fresh flag.
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic         fr1 = 1'b0;
  logic         fr0 = 1'b0;

  pipe_stage #(.DATA_W(W), .BUBBLE(BUB1), .SKID(1'b1)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_fresh(out_fresh1), .occupancy(occ1)
  );

  pipe_stage #(.DATA_W(W), .BUBBLE(BUB0), .SKID(1'b0)) dut_single (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_fresh(out_fresh0), .occupancy(occ0)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, advance the reference at the edge.
  task automatic cycle();
    logic rdy1, rdy0, acc1, acc0, drn1, drn0, was_empty;
    @(negedge clk);
    rdy1 = (q1.size() < 2);
    rdy0 = (q0.size() == 0) || out_ready;
    check_val("s1_in_ready",  W'(in_ready1), W'(rdy1));
    check_val("s1_out_valid", W'(out_valid1), W'(q1.size() > 0));
    check_val("s1_out_data",  out_data1, (q1.size() > 0) ? q1[0] : BUB1);
    check_val("s1_occupancy", W'(occ1), W'(q1.size()));
    check_val("s1_out_fresh", W'(out_fresh1), W'(fr1));
    check_val("s0_in_ready",  W'(in_ready0), W'(rdy0));
    check_val("s0_out_valid", W'(out_valid0), W'(q0.size() > 0));
    check_val("s0_out_data",  out_data0, (q0.size() > 0) ? q0[0] : BUB0);
    check_val("s0_occupancy", W'(occ0), W'(q0.size()));
    check_val("s0_out_fresh", W'(out_fresh0), W'(fr0));
    acc1 = in_valid && rdy1;
    acc0 = in_valid && rdy0;
    drn1 = (q1.size() > 0) && out_ready;
    drn0 = (q0.size() > 0) && out_ready;
    @(posedge clk);
    if (!rst || flush) begin
      q1.delete(); q0.delete(); fr1 = 1'b0; fr0 = 1'b0;
    end else begin
      was_empty = (q1.size() == 0);
      if (drn1) void'(q1.pop_front());
      if (acc1) q1.push_back(in_data);
      fr1 = (q1.size() > 0) && (was_empty || drn1);
      was_empty = (q0.size() == 0);
      if (drn0) void'(q0.pop_front());
      if (acc0) q0.push_back(in_data);
      fr0 = (q0.size() > 0) && (was_empty || drn0);
    end
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  initial begin
    logic [W-1:0] a, b, c, d;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = W'(5); out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    check_val("rst_occ",       W'(occ1), W'(0));
    check_val("rst_out_valid", W'(out_valid1), W'(0));
    check_val("rst_in_ready",  W'(in_ready1), W'(1));
    check_val("rst_bubble0",   out_data0, BUB0);
    rst = 1'b1; in_valid = 1'b0;
    cycle();

    // Streaming through the skid stage at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = rnd_data();
      send(a);
      check_val("stream_data",  out_data1, a);
      check_val("stream_fresh", W'(out_fresh1), W'(1));
      check_val("stream_occ",   W'(occ1), W'(1));
    end
    in_valid = 1'b0;
    cycle();

    // Backpressure: A held, B absorbed in skid, C held upstream.
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    out_ready = 1'b0;
    send(a);
    send(b);
    send(c);
    check_val("bp_occ",      W'(occ1), W'(2));
    check_val("bp_in_ready", W'(in_ready1), W'(0));
    check_val("bp_head",     out_data1, a);
    out_ready = 1'b1;
    send(c);
    check_val("bp_second", out_data1, b);
    send(c);
    check_val("bp_third", out_data1, c);
    in_valid = 1'b0;
    cycle();

    // Flush while full, with a simultaneous offered entry.
    out_ready = 1'b0;
    send(rnd_data());
    send(rnd_data());
    flush = 1'b1;
    send(rnd_data());
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_occ",   W'(occ1), W'(0));
    check_val("flush_valid", W'(out_valid1), W'(0));
    check_val("flush_data",  out_data1, BUB1);
    out_ready = 1'b1;
    repeat (2) cycle();

    // Single-register mode: ready follows out_ready combinationally.
    out_ready = 1'b0;
    send(rnd_data());
    in_valid = 1'b0;
    check_val("s0_ready_low", W'(in_ready0), W'(0));
    out_ready = 1'b1;
    cycle();
    check_val("s0_drain_bubble", out_data0, BUB0);
    check_val("s0_drain_valid",  W'(out_valid0), W'(0));

    // Reset while full, then reload.
    out_ready = 1'b0;
    send(rnd_data());
    send(rnd_data());
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    rst = 1'b1;
    check_val("mid_rst_occ", W'(occ1), W'(0));
    d = rnd_data();
    send(d);
    in_valid = 1'b0;
    check_val("mid_rst_fresh", W'(out_fresh1), W'(1));
    check_val("mid_rst_data",  out_data1, d);
    cycle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = rnd_data();
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 60) != 0);
      cycle();
    end
    rst = 1'b1; flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
